// File: rtl/bw_mult_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bw_mult_arbiter_pkg
// Purpose  : Shared FSM encoding, operand/product widths and the 4x4 signed
//            Baugh-Wooley multiplier used by bw_mult_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package bw_mult_arbiter_pkg;

    localparam int OP_W = 4;
    localparam int P_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Baugh-Wooley array: sign-row partial products inverted, with the
    // 2^4 + 2^7 correction folded into the initial accumulator value.
    function automatic logic [P_W-1:0] bw_mul4(input logic [OP_W-1:0] a,
                                               input logic [OP_W-1:0] b);
        logic [P_W-1:0] acc;
        acc = 8'h90;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                acc = acc + ({7'd0, a[i] & b[j]} << (i + j));
            end
            acc = acc + ({7'd0, ~(a[i] & b[3])} << (i + 3));
            acc = acc + ({7'd0, ~(a[3] & b[i])} << (i + 3));
        end
        acc = acc + ({7'd0, a[3] & b[3]} << 6);
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bw_mult_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bw_mult_arbiter_rr_arbiter
// Purpose  : Combinational round-robin picker; search starts at last+1 and
//            wraps modulo NUM_REQ. One-hot grant plus binary id.
// Revision : 1.0 - initial release
// ============================================================================
module bw_mult_arbiter_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    last,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    int              w_idx;
    logic [ID_W-1:0] w_sel;

    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        w_idx = 0;
        w_sel = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = int'(last) + off;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_sel = ID_W'(w_idx);
            if (!any && valid[w_sel]) begin
                any          = 1'b1;
                grant[w_sel] = 1'b1;
                id           = w_sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bw_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : bw_mult_arbiter
// Purpose  : Round-robin front end sharing one 4x4 signed Baugh-Wooley
//            multiplier among NUM_REQ requesters. Optional BWMA_PERF_EN adds
//            per-requester 16-bit grant counters.
// Revision : 1.0 - initial release
// ============================================================================
module bw_mult_arbiter
    import bw_mult_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [OP_W*NUM_REQ-1:0] req_a,
    input  logic [OP_W*NUM_REQ-1:0] req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [P_W-1:0]          rsp_p,
`ifdef BWMA_PERF_EN
    output logic [16*NUM_REQ-1:0]   perf_grant_cnt,
`endif
    output logic                    busy
);

    state_t              r_state;
    state_t              w_next;
    logic [ID_W-1:0]     r_last;
    logic [ID_W-1:0]     w_win_id;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_any;
    logic                w_accept;
    logic [OP_W-1:0]     r_a;
    logic [OP_W-1:0]     r_b;
    logic [OP_W-1:0]     w_sel_a;
    logic [OP_W-1:0]     w_sel_b;
    logic [OP_W-1:0]     w_mask_a [NUM_REQ];
    logic [OP_W-1:0]     w_mask_b [NUM_REQ];
    logic [P_W-1:0]      w_prod;

    bw_mult_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .valid (req_valid),
        .last  (r_last),
        .grant (w_grant),
        .id    (w_win_id),
        .any   (w_any)
    );

    // Grants are only offered from IDLE and never while reset is asserted.
    assign w_accept  = (r_state == ST_IDLE) && !rst && w_any;
    assign req_ready = w_accept ? w_grant : '0;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_opmux
        assign w_mask_a[g] = req_a[OP_W*g +: OP_W] & {OP_W{w_grant[g]}};
        assign w_mask_b[g] = req_b[OP_W*g +: OP_W] & {OP_W{w_grant[g]}};
    end

    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sel_a = w_sel_a | w_mask_a[i];
            w_sel_b = w_sel_b | w_mask_b[i];
        end
    end

    assign w_prod = bw_mul4(r_a, r_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: if (w_accept)  w_next = ST_MUL;
            ST_MUL:                 w_next = ST_HOLD;
            ST_HOLD: if (rsp_ready) w_next = ST_IDLE;
            default:                w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_last    <= ID_W'(NUM_REQ - 1);
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_p     <= '0;
        end else begin
            if (w_accept) begin
                r_a    <= w_sel_a;
                r_b    <= w_sel_b;
                r_last <= w_win_id;
                rsp_id <= w_win_id;
            end
            if (r_state == ST_MUL) begin
                rsp_p     <= w_prod;
                rsp_valid <= 1'b1;
            end else if (r_state == ST_HOLD && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

`ifdef BWMA_PERF_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
        logic [15:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_accept && w_grant[g]) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
        assign perf_grant_cnt[16*g +: 16] = r_cnt;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bw_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_bw_mult_arbiter
// Purpose  : Self-checking bench for bw_mult_arbiter: directed tables,
//            multi-cycle corner sequences and randomized traffic vs a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bw_mult_arbiter;

    localparam int N  = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [4*N-1:0]  req_a;
    logic [4*N-1:0]  req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [7:0]      rsp_p;
    logic            busy;
`ifdef BWMA_PERF_EN
    logic [16*N-1:0] perf_grant_cnt;
`endif

    always #5 clk = ~clk;

    bw_mult_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_a          (req_a),
        .req_b          (req_b),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_id         (rsp_id),
        .rsp_p          (rsp_p),
`ifdef BWMA_PERF_EN
        .perf_grant_cnt (perf_grant_cnt),
`endif
        .busy           (busy)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    // Requester-side model: pending flags and held operands, rr pointer, grant counts.
    bit         pend [N];
    logic [3:0] pa   [N];
    logic [3:0] pb   [N];
    int         m_last;
    int         m_cnt [N];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        logic [N-1:0] t;
        for (int k = 1; k <= N; k++) begin
            t = mask >> ((last + k) % N);
            if (t[0]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        return 8'(sa * sb);
    endfunction

    task automatic drive();
        logic [N-1:0]   m;
        logic [4*N-1:0] va;
        logic [4*N-1:0] vb;
        m = '0; va = '0; vb = '0;
        for (int i = N - 1; i >= 0; i--) begin
            m  = {m[N-2:0], pend[i]};
            va = {va[4*N-5:0], pa[i]};
            vb = {vb[4*N-5:0], pb[i]};
        end
        req_valid = m;
        req_a     = va;
        req_b     = vb;
    endtask

    task automatic model_reset();
        m_last = N - 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        drive();
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    // One full transaction from IDLE: accept, MUL, HOLD (hold extra cycles), release.
    task automatic txn(input int hold, input string tag,
                       output logic [7:0] got_p, output logic [IW-1:0] got_id);
        logic [N-1:0] mask;
        logic [7:0]   exp_p;
        int           w;
        drive();
        rsp_ready = 1'b0;
        mask = req_valid;
        w = rr_pick(mask, m_last);
        got_p  = '0;
        got_id = '0;
        #1;
        if (w < 0) begin
            chk({tag, " no pending requester"}, 32'd0, 32'd1);
            return;
        end
        exp_p = ref_mul(pa[w], pb[w]);
        chk({tag, " req_ready"}, req_ready, N'(1) << w);
        tick();
        pend[w] = 1'b0;
        m_last  = w;
        m_cnt[w]++;
        drive();
        #1;
        chk({tag, " busy in MUL"}, busy, 1);
        chk({tag, " rsp_valid in MUL"}, rsp_valid, 0);
        chk({tag, " req_ready in MUL"}, req_ready, 0);
        tick();
        chk({tag, " rsp_valid"}, rsp_valid, 1);
        chk({tag, " rsp_id"}, rsp_id, w);
        chk({tag, " rsp_p"}, rsp_p, exp_p);
        got_p  = rsp_p;
        got_id = rsp_id;
        for (int h = 0; h < hold; h++) begin
            tick();
            chk({tag, " hold rsp_valid"}, rsp_valid, 1);
            chk({tag, " hold rsp_p"}, rsp_p, exp_p);
            chk({tag, " hold rsp_id"}, rsp_id, w);
            chk({tag, " hold req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, " rsp_valid after release"}, rsp_valid, 0);
        chk({tag, " busy after release"}, busy, 0);
    endtask

`ifdef BWMA_PERF_EN
    task automatic chk_perf(input string tag);
        logic [16*N-1:0] t;
        for (int i = 0; i < N; i++) begin
            t = perf_grant_cnt >> (16 * i);
            chk(tag, t[15:0], m_cnt[i][15:0]);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [10];
        logic [7:0] gp;
        logic [IW-1:0] gid;
        int         nres;
        int         last_cyc;
        int         cyc;

        tbl[0] = '{4'h8, 4'h8, 8'h40};
        tbl[1] = '{4'h8, 4'h7, 8'hC8};
        tbl[2] = '{4'h7, 4'h7, 8'h31};
        tbl[3] = '{4'hF, 4'hF, 8'h01};
        tbl[4] = '{4'h7, 4'h8, 8'hC8};
        tbl[5] = '{4'h0, 4'h5, 8'h00};
        tbl[6] = '{4'h3, 4'hE, 8'hFA};
        tbl[7] = '{4'hB, 4'h3, 8'hF1};
        tbl[8] = '{4'h8, 4'h1, 8'hF8};
        tbl[9] = '{4'h1, 4'hF, 8'hFF};

        // Reset with every requester asserting valid.
        rst = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; pa[i] = 4'(i + 1); pb[i] = 4'(i + 2);
        end
        drive();
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("reset req_ready", req_ready, 0);
            chk("reset rsp_valid", rsp_valid, 0);
            chk("reset busy", busy, 0);
            chk("reset rsp_p", rsp_p, 0);
            chk("reset rsp_id", rsp_id, 0);
        end
`ifdef BWMA_PERF_EN
        model_reset();
        chk_perf("perf after reset");
`endif
        rst = 1'b0;
        model_reset();
        #1;
        chk("first grant", req_ready, 4'b0001);
        txn(0, "first", gp, gid);
        chk("first id", gid, 0);
        for (int i = 0; i < N; i++) pend[i] = 1'b0;

        for (int i = 0; i < 10; i++) begin
            pend[0] = 1'b1; pa[0] = tbl[i].a; pb[0] = tbl[i].b;
            txn(0, "ext", gp, gid);
            chk("ext table product", gp, tbl[i].p);
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                pend[0] = 1'b1; pa[0] = 4'(a); pb[0] = 4'(b);
                txn(0, "sweep", gp, gid);
            end
        end

        // Fairness with rsp_ready tied high: ids 0,1,2,3,... every 3 cycles.
        do_reset();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; pa[i] = 4'($urandom); pb[i] = 4'($urandom);
        end
        drive();
        rsp_ready = 1'b1;
        nres = 0; last_cyc = 0; cyc = 0;
        while (nres < 8 && cyc < 60) begin
            tick();
            cyc++;
            if (rsp_valid) begin
                chk("fair rsp_id", rsp_id, nres % N);
                chk("fair rsp_p", rsp_p, ref_mul(pa[nres % N], pb[nres % N]));
                if (nres > 0) chk("fair spacing", cyc - last_cyc, 3);
                m_cnt[nres % N]++;
                m_last = nres % N;
                last_cyc = cyc;
                nres++;
                if (nres == 8) begin
                    for (int i = 0; i < N; i++) pend[i] = 1'b0;
                    drive();
                end
            end
        end
        chk("fair product count", nres, 8);
        tick();
        rsp_ready = 1'b0;
        chk("fair back to idle", busy, 0);
`ifdef BWMA_PERF_EN
        chk_perf("perf after fairness");
`endif

        // Backpressure: 5 stalled HOLD cycles with other requesters waiting.
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b1; pa[i] = 4'($urandom); pb[i] = 4'($urandom);
        end
        txn(5, "bp", gp, gid);
        while (pend[0] || pend[1] || pend[2] || pend[3]) txn(1, "bp drain", gp, gid);

        // Sparse requests exercise pointer wrap.
        do_reset();
        pend[2] = 1'b1; pa[2] = 4'h3; pb[2] = 4'h5;
        txn(0, "sparse", gp, gid);
        chk("sparse first id", gid, 2);
        pend[1] = 1'b1; pa[1] = 4'hC; pb[1] = 4'h2;
        txn(0, "sparse", gp, gid);
        chk("sparse wrap id", gid, 1);
        pend[1] = 1'b1; pend[2] = 1'b1;
        txn(0, "sparse", gp, gid);
        chk("sparse both id", gid, 2);
        txn(0, "sparse", gp, gid);
        chk("sparse remaining id", gid, 1);

        // Reset asserted while the accepted operation sits in MUL.
        pend[0] = 1'b1; pa[0] = 4'h7; pb[0] = 4'h7;
        drive();
        tick();
        pend[0] = 1'b0;
        drive();
        chk("midop in MUL", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("midop rsp_valid", rsp_valid, 0);
        chk("midop busy", busy, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("midop no pulse", rsp_valid, 0);
        end
`ifdef BWMA_PERF_EN
        chk_perf("perf after midop reset");
`endif
        pend[3] = 1'b1; pa[3] = 4'h9; pb[3] = 4'h6;
        txn(0, "post reset", gp, gid);

        // Randomized traffic with held pending requests.
        for (int it = 0; it < 80; it++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1; pa[i] = 4'($urandom); pb[i] = 4'($urandom);
                end
            end
            if (!(pend[0] || pend[1] || pend[2] || pend[3])) begin
                pend[it % N] = 1'b1; pa[it % N] = 4'($urandom); pb[it % N] = 4'($urandom);
            end
            txn(int'($urandom_range(0, 3)), "rand", gp, gid);
        end
`ifdef BWMA_PERF_EN
        chk_perf("perf final");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
